// File: rtl/calc_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer driving one shared external 16-bit add/sub unit.
// Optional feature: define CALC_DIV0_ERR_EN to flag divide-by-zero (result 16'hFFFF, err=1).
module calc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  remainder,
    output logic        err,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_sub,
    input  logic [15:0] alu_r
);

`ifdef CALC_DIV0_ERR_EN
    localparam bit DIV0_ERR = 1'b1;
`else
    localparam bit DIV0_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state_reg;
    logic [15:0] acc_reg;
    logic [7:0]  cnt_reg;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [1:0]  op_reg;

    logic [7:0]  cnt_dec;
    logic [7:0]  cnt_inc;
    logic        div_more;

    assign cnt_dec  = cnt_reg - 8'd1;
    assign cnt_inc  = cnt_reg + 8'd1;
    // During division acc never exceeds a, so its low byte is the whole value.
    assign div_more = (alu_r[7:0] >= b_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= OP_ADD;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            err       <= 1'b0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_sub   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                acc_reg   <= {8'd0, a};
                                cnt_reg   <= '0;
                                state_reg <= S_EXEC;
                                alu_x     <= {8'd0, a};
                                alu_y     <= {8'd0, b};
                                alu_sub   <= (op == OP_SUB);
                            end
                            OP_MUL: begin
                                acc_reg <= '0;
                                cnt_reg <= b;
                                if (b == 8'd0) begin
                                    state_reg <= S_DONE;
                                    done      <= 1'b1;
                                    result    <= '0;
                                    remainder <= '0;
                                end else begin
                                    state_reg <= S_EXEC;
                                    alu_x     <= '0;
                                    alu_y     <= {8'd0, a};
                                    alu_sub   <= 1'b0;
                                end
                            end
                            default: begin
                                acc_reg <= {8'd0, a};
                                cnt_reg <= '0;
                                if (b == 8'd0 || a < b) begin
                                    state_reg <= S_DONE;
                                    done      <= 1'b1;
                                    result    <= (b == 8'd0 && DIV0_ERR) ? 16'hFFFF : 16'h0000;
                                    remainder <= a;
                                    err       <= (b == 8'd0) && DIV0_ERR;
                                end else begin
                                    state_reg <= S_EXEC;
                                    alu_x     <= {8'd0, a};
                                    alu_y     <= {8'd0, b};
                                    alu_sub   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                S_EXEC: begin
                    acc_reg <= alu_r;
                    // Default: leave EXEC with the ALU bus idle; overridden when iterating.
                    alu_x   <= '0;
                    alu_y   <= '0;
                    alu_sub <= 1'b0;
                    case (op_reg)
                        OP_ADD, OP_SUB: begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            result    <= alu_r;
                            remainder <= '0;
                        end
                        OP_MUL: begin
                            cnt_reg <= cnt_dec;
                            if (cnt_dec == 8'd0) begin
                                state_reg <= S_DONE;
                                done      <= 1'b1;
                                result    <= alu_r;
                                remainder <= '0;
                            end else begin
                                alu_x <= alu_r;
                                alu_y <= {8'd0, a_reg};
                            end
                        end
                        default: begin
                            cnt_reg <= cnt_inc;
                            if (div_more) begin
                                alu_x   <= alu_r;
                                alu_y   <= {8'd0, b_reg};
                                alu_sub <= 1'b1;
                            end else begin
                                state_reg <= S_DONE;
                                done      <= 1'b1;
                                result    <= {8'd0, cnt_inc};
                                remainder <= alu_r[7:0];
                            end
                        end
                    endcase
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
